// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: glitch-filtered, multiplexed 4-digit hex display driver for an asynchronous ripple-counter value.
module seg7_scan_driver #(
  parameter int WIDTH = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int LEADING_BLANK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             hold,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);
  localparam int PW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [15:0] shown;
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic [3:0] nib, an_n;
  logic [6:0] seg_n;
  logic blank, wrap;
  function automatic logic [6:0] enc(input logic [3:0] h);
    case (h)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'ha: enc = 7'b0001000;
      4'hb: enc = 7'b0000011;
      4'hc: enc = 7'b1000110;
      4'hd: enc = 7'b0100001;
      4'he: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction
  always_comb begin
    nib = shown[{idx, 2'b00} +: 4];
    blank = LEADING_BLANK != 0 && idx != 2'd0 && (shown >> {idx, 2'b00}) == 16'd0;
    an_n = blank ? 4'hf : ~(4'b0001 << idx);
    seg_n = blank ? 7'h7f : enc(nib);
    wrap = presc == PW'(REFRESH_DIV - 1);
  end
  // shown only takes a sample seen identically on two consecutive edges, so ripple glitches never reach it
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      shown <= '0;
      presc <= '0;
      idx <= '0;
      an <= 4'hf;
      seg <= 7'h7f;
      dp <= 1'b1;
    end else begin
      s1 <= value;
      s2 <= s1;
      s3 <= s2;
      if (s2 == s3 && !hold) shown <= 16'(s2);
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) idx <= idx + 2'd1;
      an <= an_n;
      seg <= seg_n;
      dp <= ~(idx == 2'd0 && hold);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench for two seg7_scan_driver configurations.
module tb_seg7_scan_driver;
  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] shown;
  } exp_t;
  localparam int DIV = 4;
  localparam logic [6:0] ENC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clk = 0, reset = 0, hold = 0;
  logic [15:0] v16 = 0;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic dp0, dp1;
  int tests = 0, fails = 0, cyc = 0;
  exp_t q0[$], q1[$];
  int t[2], n[2];
  logic [15:0] shown_m[2];
  logic [15:0] samp[2][4096];

  seg7_scan_driver #(.WIDTH(8), .REFRESH_DIV(DIV), .LEADING_BLANK(1)) u0 (
    .clk(clk), .reset(reset), .value(v16[7:0]), .hold(hold), .an(an0), .seg(seg0), .dp(dp0));
  seg7_scan_driver #(.WIDTH(16), .REFRESH_DIV(DIV), .LEADING_BLANK(0)) u1 (
    .clk(clk), .reset(reset), .value(v16), .hold(hold), .an(an1), .seg(seg1), .dp(dp1));

  always #5 clk = ~clk;

  // Reference: digit slot = elapsed cycles / DIV mod 4; display takes a sample once it repeats on two edges.
  task automatic model(input int d, input int lb, input logic [15:0] v, input logic h, input logic r, output exp_t e);
    int idx;
    logic [15:0] upper;
    if (r) begin
      t[d] = 0;
      shown_m[d] = 0;
      for (int i = 0; i < 3; i++) samp[d][i] = 0;
      n[d] = 3;
      e = '{an: 4'hf, seg: 7'h7f, dp: 1'b1, shown: 16'h0};
    end else begin
      idx = (t[d] / DIV) % 4;
      upper = shown_m[d] / (16'd1 << (4 * idx));
      e.an = 4'hf;
      e.seg = 7'h7f;
      if (lb == 0 || idx == 0 || upper != 0) begin
        e.an[idx] = 1'b0;
        e.seg = ENC[upper % 16];
      end
      e.dp = (idx == 0 && h) ? 1'b0 : 1'b1;
      if (samp[d][n[d]-2] == samp[d][n[d]-3] && !h) shown_m[d] = samp[d][n[d]-2];
      e.shown = shown_m[d];
      samp[d][n[d]] = v;
      n[d]++;
      t[d]++;
    end
  endtask

  task automatic tick(input logic [15:0] v, input logic h, input logic r);
    exp_t e;
    @(negedge clk);
    v16 = v;
    hold = h;
    reset = r;
    @(posedge clk);
    model(0, 1, {8'h00, v[7:0]}, h, r, e);
    q0.push_back(e);
    model(1, 0, v, h, r, e);
    q1.push_back(e);
  endtask

  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        g = '{an: an0, seg: seg0, dp: dp0, shown: u0.shown};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL dut0 cyc %0d: got an=%b seg=%b dp=%b shown=%h, want an=%b seg=%b dp=%b shown=%h",
                   cyc, g.an, g.seg, g.dp, g.shown, e.an, e.seg, e.dp, e.shown);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        g = '{an: an1, seg: seg1, dp: dp1, shown: u1.shown};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL dut1 cyc %0d: got an=%b seg=%b dp=%b shown=%h, want an=%b seg=%b dp=%b shown=%h",
                   cyc, g.an, g.seg, g.dp, g.shown, e.an, e.seg, e.dp, e.shown);
        end
      end
    end
  end

  initial begin
    logic h;
    logic [15:0] v;
    int guard;
    n[0] = 3;
    n[1] = 3;
    tick(0, 0, 1);
    tick(0, 0, 1);
    for (int i = 0; i < 20; i++) tick(16'h0000, 0, 0);
    for (int i = 0; i < 20; i++) tick(16'h00a5, 0, 0);
    tick(0, 0, 1);
    for (int i = 0; i < 20; i++) tick(i % 2 ? 16'h0080 : 16'h007f, 0, 0);
    for (int i = 0; i < 20; i++) tick(16'h0080, 0, 0);
    for (int i = 0; i < 8; i++) tick(16'h0012, 0, 0);
    for (int i = 0; i < 20; i++) tick(16'h0034, 1, 0);
    for (int i = 0; i < 10; i++) tick(16'h0034, 0, 0);
    guard = 0;
    while ((t[0] / DIV) % 4 != 2 && guard < 32) begin
      tick(16'h0034, 0, 0);
      guard++;
    end
    tests++;
    if (guard >= 32) begin
      fails++;
      $display("FAIL idx2_wait: got no idx=2 slot within %0d cycles, want one", guard);
    end
    tick(16'h0034, 0, 1);
    for (int i = 0; i < 20; i++) tick(16'h0f00, 0, 0);
    v = 0;
    h = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) v = 16'($urandom);
      if ($urandom_range(7) == 0) h = ~h;
      tick(v, h, $urandom_range(99) == 0);
    end
    tick(v, 0, 0);
    @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
